// File: rtl/spi_sequencer.sv
// SPI transaction sequencer: loads TX bytes into the SPI data registers, kicks the
// control register, polls for completion, then streams the received bytes back out.
module spi_sequencer #(
   parameter int MAX_BYTES = 16,
   parameter int TIMEOUT   = 65535
) (
   input  logic        clk_pi,
   input  logic        reset_pi,
   input  logic        start_i,
   input  logic [9:0]  n_bytes_i,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   output logic [7:0]  rx_data_o,
   output logic        rx_valid_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        spi_wr_o,
   output logic        spi_reg_sel_o,
   output logic [31:0] spi_data_o,
   output logic [9:0]  spi_addr_o,
   input  logic [31:0] spi_data_i
);

   localparam int              CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [9:0]      MAX_N     = 10'(MAX_BYTES);
   localparam logic [CW-1:0]   POLL_LAST = CW'(TIMEOUT - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] CONFIG = 3'd2;
   localparam logic [2:0] WAIT   = 3'd3;
   localparam logic [2:0] POLL   = 3'd4;
   localparam logic [2:0] READ   = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;
   localparam logic [2:0] ERR    = 3'd7;

   logic [2:0]    state_reg, state_next;
   logic [9:0]    n_reg, n_next;
   logic [9:0]    k_reg, k_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [7:0]    rx_data_reg;
   logic          rx_valid_reg;

   logic [9:0]    n_last;
   logic          k_last;
   logic          n_ok;
   logic          wr_data;
   logic [31:0]   ctrl_word;
   logic          unused_bits;

   assign n_last  = n_reg - 10'd1;
   assign k_last  = (k_reg == n_last);
   assign n_ok    = (n_bytes_i != 10'd0) && (n_bytes_i <= MAX_N);
   assign wr_data = (state_reg == LOAD) && tx_valid_i;

   // Control word: send=1, n_tx_end=N-1, n_rx=0; cs_ctrl/all_1s/all_0s stay 0.
   assign ctrl_word = {6'b0, 10'b0, 3'b0, n_last[8:0], 4'b0001};

   // Only the low byte and the busy bit of the SPI read bus matter here.
   assign unused_bits = ^spi_data_i[31:8];

   always_comb begin
      state_next = state_reg;
      n_next     = n_reg;
      k_next     = k_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               if (n_ok) begin
                  state_next = LOAD;
                  n_next     = n_bytes_i;
                  k_next     = 10'd0;
               end else begin
                  state_next = ERR;
               end
            end
         end
         LOAD: begin
            if (tx_valid_i) begin
               if (k_last) begin
                  state_next = CONFIG;
                  k_next     = 10'd0;
               end else begin
                  k_next = k_reg + 10'd1;
               end
            end
         end
         CONFIG: begin
            state_next = WAIT;
            cnt_next   = '0;
         end
         WAIT: begin
            if (cnt_reg == CW'(1)) begin
               state_next = POLL;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         POLL: begin
            if (!spi_data_i[0]) begin
               state_next = READ;
               k_next     = 10'd0;
               cnt_next   = '0;
            end else if (cnt_reg == POLL_LAST) begin
               state_next = ERR;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         READ: begin
            if (k_last) begin
               state_next = DONE;
               k_next     = 10'd0;
            end else begin
               k_next = k_reg + 10'd1;
            end
         end
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi) begin
         state_reg    <= IDLE;
         n_reg        <= 10'd0;
         k_reg        <= 10'd0;
         cnt_reg      <= '0;
         rx_data_reg  <= 8'd0;
         rx_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         n_reg        <= n_next;
         k_reg        <= k_next;
         cnt_reg      <= cnt_next;
         rx_valid_reg <= (state_reg == READ);
         if (state_reg == READ) begin
            rx_data_reg <= spi_data_i[7:0];
         end
      end
   end

   // Outputs decode straight from state so an asynchronous reset clears them at once.
   assign busy_o        = (state_reg != IDLE);
   assign done_o        = (state_reg == DONE);
   assign err_o         = (state_reg == ERR);
   assign tx_ready_o    = (state_reg == LOAD);
   assign rx_valid_o    = rx_valid_reg;
   assign rx_data_o     = rx_data_reg;
   assign spi_wr_o      = wr_data || (state_reg == CONFIG);
   assign spi_reg_sel_o = wr_data || (state_reg == READ);
   assign spi_addr_o    = (wr_data || (state_reg == READ)) ? k_reg : 10'd0;
   assign spi_data_o    = wr_data ? {24'b0, tx_data_i} :
                          (state_reg == CONFIG) ? ctrl_word : 32'd0;

endmodule

// File: tb/tb_spi_sequencer.sv
// Randomized bench for spi_sequencer: a behavioural SPI register model plus
// per-transaction expectations derived from byte lists and cycle arithmetic.
module tb_spi_sequencer;

   localparam int MAXB  = 16;
   localparam int TMO   = 100;
   localparam int NEVER = 100000;

   logic        clk_pi = 1'b0;
   logic        reset_pi = 1'b1;
   logic        start_i = 1'b0;
   logic [9:0]  n_bytes_i = 10'd0;
   logic [7:0]  tx_data_i = 8'd0;
   logic        tx_valid_i = 1'b0;
   logic        tx_ready_o;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        spi_wr_o;
   logic        spi_reg_sel_o;
   logic [31:0] spi_data_o;
   logic [9:0]  spi_addr_o;
   logic [31:0] spi_data_i;

   spi_sequencer #(.MAX_BYTES(MAXB), .TIMEOUT(TMO)) dut (
      .clk_pi        (clk_pi),
      .reset_pi      (reset_pi),
      .start_i       (start_i),
      .n_bytes_i     (n_bytes_i),
      .tx_data_i     (tx_data_i),
      .tx_valid_i    (tx_valid_i),
      .tx_ready_o    (tx_ready_o),
      .rx_data_o     (rx_data_o),
      .rx_valid_o    (rx_valid_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .spi_wr_o      (spi_wr_o),
      .spi_reg_sel_o (spi_reg_sel_o),
      .spi_data_o    (spi_data_o),
      .spi_addr_o    (spi_addr_o),
      .spi_data_i    (spi_data_i)
   );

   always #5 clk_pi = ~clk_pi;

   int cyc = 0;
   always @(posedge clk_pi) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // SPI model: loopback data registers, send bit clears spi_delay cycles after the control write.
   logic [31:0] spi_mem [0:511];
   logic [31:0] spi_ctrl;
   int          spi_cnt;
   int          spi_delay = 40;

   initial for (int i = 0; i < 512; i++) spi_mem[i] = 32'd0;

   always @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi) begin
         spi_ctrl <= 32'd0;
         spi_cnt  <= 0;
      end else if (spi_wr_o) begin
         if (spi_reg_sel_o) begin
            spi_mem[spi_addr_o[8:0]] <= spi_data_o;
         end else begin
            spi_ctrl <= spi_data_o;
            spi_cnt  <= spi_delay;
         end
      end else if (spi_ctrl[0]) begin
         if (spi_cnt <= 1) spi_ctrl[0] <= 1'b0;
         else spi_cnt <= spi_cnt - 1;
      end
   end

   assign spi_data_i = spi_reg_sel_o ? spi_mem[spi_addr_o[8:0]] : spi_ctrl;

   // Monitor, sampled on the falling edge.
   typedef struct packed {
      logic        sel;
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t        wr_q[$];
   logic [7:0] rx_q[$];
   int         rx_t[$];
   int         done_q[$];
   int         err_q[$];

   always @(negedge clk_pi) begin
      if (spi_wr_o) wr_q.push_back({spi_reg_sel_o, spi_addr_o, spi_data_o});
      if (rx_valid_o) begin
         rx_q.push_back(rx_data_o);
         rx_t.push_back(cyc);
      end
      if (done_o) done_q.push_back(cyc);
      if (err_o)  err_q.push_back(cyc);
   end

   logic [7:0] tx_bytes[$];

   task automatic clear_mon();
      wr_q.delete();
      rx_q.delete();
      rx_t.delete();
      done_q.delete();
      err_q.delete();
   endtask

   task automatic fill_random(input int n);
      tx_bytes.delete();
      for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
   endtask

   task automatic do_start(input int n, output int s);
      @(negedge clk_pi);
      start_i   = 1'b1;
      n_bytes_i = 10'(n);
      s         = cyc;
      @(negedge clk_pi);
      start_i   = 1'b0;
   endtask

   task automatic do_feed(input int n, input int stall_at, input int stall_len);
      int  i = 0;
      int  stall_cnt = 0;
      int  guard = 0;
      bit  acc;
      bit  stalling;
      while (i < n && guard < 300) begin
         stalling   = (i == stall_at) && (stall_cnt < stall_len);
         tx_valid_i = !stalling;
         tx_data_i  = tx_bytes[i];
         acc        = tx_ready_o && tx_valid_i;
         if (stalling) stall_cnt++;
         @(negedge clk_pi);
         if (acc) i++;
         guard++;
      end
      tx_valid_i = 1'b0;
      check("feed_in_time", 64'(guard < 300), 64'd1);
   endtask

   // One transaction; expectations come from the byte list and cycle arithmetic.
   task automatic run_txn(input string name, input int n, input int delay,
                          input int stall_at, input int stall_len, input bit poke);
      int  s;
      int  guard = 0;
      int  p;
      int  lat;
      int  nw;
      bit  ok_n = (n >= 1) && (n <= MAXB);
      clear_mon();
      spi_delay = delay;
      do_start(n, s);
      check({name, "_busy_start"}, 64'(busy_o), 64'd1);
      if (ok_n) begin
         do_feed(n, stall_at, stall_len);
         if (poke) begin
            check({name, "_busy_poke"}, 64'(busy_o), 64'd1);
            start_i   = 1'b1;
            n_bytes_i = 10'd5;
            @(negedge clk_pi);
            start_i   = 1'b0;
         end
      end
      while (!(done_o || err_o) && guard < 400) begin
         @(negedge clk_pi);
         guard++;
      end
      check({name, "_ended"}, 64'(guard < 400), 64'd1);
      @(negedge clk_pi);
      check({name, "_busy_after"}, 64'(busy_o), 64'd0);

      nw = wr_q.size();
      if (!ok_n) begin
         check({name, "_wr_count"}, 64'(nw), 64'd0);
         check({name, "_err_count"}, 64'(err_q.size()), 64'd1);
         check({name, "_done_count"}, 64'(done_q.size()), 64'd0);
         check({name, "_err_lat"}, 64'(err_q.size() > 0 ? err_q[0] - s : -1), 64'd1);
      end else begin
         check({name, "_wr_count"}, 64'(nw), 64'(n + 1));
         for (int i = 0; i < n && i < nw; i++)
            check({name, "_data_wr"}, 64'(wr_q[i]), 64'({1'b1, 10'(i), 24'h0, tx_bytes[i]}));
         if (nw > n)
            check({name, "_ctrl_wr"}, 64'(wr_q[n]),
                  64'({1'b0, 10'd0, 32'h1 | (32'(n - 1) << 4)}));
         if (delay >= NEVER) begin
            lat = n + stall_len + 1 + 2 + TMO + 1;
            check({name, "_rx_count"}, 64'(rx_q.size()), 64'd0);
            check({name, "_err_count"}, 64'(err_q.size()), 64'd1);
            check({name, "_done_count"}, 64'(done_q.size()), 64'd0);
            check({name, "_err_lat"}, 64'(err_q.size() > 0 ? err_q[0] - s : -1), 64'(lat));
         end else begin
            p   = ((delay - 2) > 0 ? (delay - 2) : 0) + 1;
            lat = 2 * n + 4 + p + stall_len;
            check({name, "_rx_count"}, 64'(rx_q.size()), 64'(n));
            for (int i = 0; i < n && i < rx_q.size(); i++)
               check({name, "_rx_byte"}, 64'(rx_q[i]), 64'(tx_bytes[i]));
            check({name, "_done_count"}, 64'(done_q.size()), 64'd1);
            check({name, "_err_count"}, 64'(err_q.size()), 64'd0);
            check({name, "_done_lat"}, 64'(done_q.size() > 0 ? done_q[0] - s : -1), 64'(lat));
            if (rx_t.size() > 0 && done_q.size() > 0)
               check({name, "_last_rx_at_done"}, 64'(rx_t[rx_t.size() - 1]), 64'(done_q[0]));
         end
      end
      $display("txn %s: n=%0d delay=%0d stall=%0d writes=%0d rx=%0d done=%0d err=%0d",
               name, n, delay, stall_len, nw, rx_q.size(), done_q.size(), err_q.size());
   endtask

   initial begin
      int s;
      int n;

      repeat (3) @(negedge clk_pi);
      check("reset_outputs", 64'({busy_o, done_o, err_o, rx_valid_o, tx_ready_o, spi_wr_o,
                                  spi_reg_sel_o, spi_data_o, spi_addr_o, rx_data_o}), 64'd0);
      reset_pi = 1'b0;
      @(negedge clk_pi);

      // Directed three-byte transfer
      tx_bytes.delete();
      tx_bytes.push_back(8'hA5);
      tx_bytes.push_back(8'h3C);
      tx_bytes.push_back(8'hFF);
      run_txn("basic3", 3, 40, -1, 0, 1'b0);

      // Out-of-range byte counts
      run_txn("n0", 0, 40, -1, 0, 1'b0);
      run_txn("n17", MAXB + 1, 40, -1, 0, 1'b0);

      // SPI never finishes
      fill_random(2);
      run_txn("timeout", 2, NEVER, -1, 0, 1'b0);

      // Producer stalls five cycles between bytes 1 and 2
      fill_random(4);
      run_txn("stall4", 4, 12, 2, 5, 1'b0);

      // Reset while polling, then a fresh transaction
      clear_mon();
      spi_delay = NEVER;
      fill_random(3);
      do_start(3, s);
      do_feed(3, -1, 0);
      repeat (10) @(negedge clk_pi);
      check("busy_in_poll", 64'(busy_o), 64'd1);
      #2;
      reset_pi = 1'b1;
      #1;
      check("reset_in_poll", 64'({busy_o, done_o, err_o, rx_valid_o, tx_ready_o, spi_wr_o,
                                  spi_reg_sel_o, spi_data_o, spi_addr_o, rx_data_o}), 64'd0);
      @(negedge clk_pi);
      reset_pi = 1'b0;
      repeat (TMO + 20) @(negedge clk_pi);
      check("reset_no_pulses", 64'(done_q.size() + err_q.size()), 64'd0);
      $display("txn reset_in_poll: done=%0d err=%0d", done_q.size(), err_q.size());
      fill_random(5);
      run_txn("after_reset", 5, 20, -1, 0, 1'b0);

      // start_i pulsed while busy
      fill_random(6);
      run_txn("poke", 6, 30, -1, 0, 1'b1);

      // Largest transaction
      fill_random(MAXB);
      run_txn("max", MAXB, 25, -1, 0, 1'b0);

      // Randomized transactions
      for (int t = 0; t < 20; t++) begin
         n = int'($urandom_range(1, MAXB));
         fill_random(n);
         run_txn("rand", n, int'($urandom_range(1, 60)), int'($urandom_range(0, n - 1)),
                 int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_sequencer.md
SPI_SEQUENCER -- requirements
Module: spi_sequencer

Interface
REQ-001 The module SHALL have a parameter MAX_BYTES, default 16, giving the maximum bytes per transaction (2..512).
REQ-002 The module SHALL have a parameter TIMEOUT, default 65535, giving the poll limit in clk_pi cycles.
REQ-003 clk_pi  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset_pi  in  1  reset, asynchronous and active-high.
REQ-005 start_i  in  1  one-cycle request to begin a transaction; sampled only in IDLE.
REQ-006 n_bytes_i  in  10  byte count; sampled with start_i.
REQ-007 tx_data_i  in  8  byte to transmit; tx_valid_i  in  1  byte valid; tx_ready_o  out  1  sequencer accepts byte.
REQ-008 rx_data_o  out  8  received byte; rx_valid_o  out  1  one-cycle qualifier for rx_data_o.
REQ-009 busy_o  out  1  high in every state except IDLE; done_o  out  1  one-cycle completion pulse; err_o  out  1  one-cycle error pulse.
REQ-010 spi_wr_o  out  1  SPI write enable; spi_reg_sel_o  out  1  0 = control register, 1 = data register.
REQ-011 spi_data_o  out  32  SPI write data; spi_addr_o  out  10  SPI data-register address; spi_data_i  in  32  SPI read data (combinational from SPI).

Function
REQ-012 SPI control word fields SHALL be: bit0 send, bit1 cs_ctrl, bit2 all_1s, bit3 all_0s, [12:4] n_tx_end, [25:16] n_rx; all other bits 0.
REQ-013 States SHALL be IDLE, LOAD, CONFIG, WAIT, POLL, READ, DONE, ERR.
REQ-014 IDLE: start_i=1 with 1<=n_bytes_i<=MAX_BYTES -> LOAD, latch N=n_bytes_i, clear byte index k=0; start_i=1 with other n_bytes_i -> ERR; start_i outside IDLE SHALL be ignored.
REQ-015 LOAD: tx_ready_o=1; each cycle with tx_valid_i=1 SHALL write {24'b0, tx_data_i} to data register address k (spi_wr_o=1, spi_reg_sel_o=1, spi_addr_o=k) and increment k.
REQ-016 LOAD: tx_valid_i=0 SHALL stall without timeout; after byte N-1 is accepted -> CONFIG, k=0.
REQ-017 CONFIG: one cycle, SHALL write control word send=1, cs_ctrl=0, all_1s=0, all_0s=0, n_tx_end=N-1, n_rx=0 (spi_wr_o=1, spi_reg_sel_o=0) -> WAIT.
REQ-018 WAIT: exactly 2 cycles with spi_wr_o=0, no sampling of spi_data_i -> POLL; poll counter cleared.
REQ-019 POLL: spi_wr_o=0, spi_reg_sel_o=0; spi_data_i[0]=0 -> READ with k=0; else increment counter; counter reaching TIMEOUT -> ERR.
REQ-020 READ: spi_reg_sel_o=1, spi_addr_o=k, spi_wr_o=0; rx_data_o SHALL be spi_data_i[7:0] registered, rx_valid_o=1 one cycle after address k is presented, one byte per cycle, no backpressure.
REQ-021 After address N-1 is presented -> DONE; rx_valid_o for byte N-1 SHALL coincide with the DONE cycle.
REQ-022 DONE: done_o=1 for one cycle -> IDLE. ERR: err_o=1 for one cycle, no SPI write -> IDLE.
REQ-023 Total latency start_i to done_o with tx_valid_i held high SHALL be N+1 (LOAD+CONFIG) + 2 (WAIT) + P (POLL cycles, >=1) + N (READ) + 1 cycles.
REQ-024 spi_wr_o SHALL be high only in LOAD (accepted byte) and CONFIG; spi_data_o, spi_addr_o SHALL be 0 when unused.
REQ-025 k SHALL be 10 bits, never wrap within a transaction; N=MAX_BYTES SHALL use addresses 0..MAX_BYTES-1 only.

Reset
REQ-026 reset_pi high SHALL immediately force IDLE, k=0, counter=0, and all outputs 0 (busy_o, done_o, err_o, rx_valid_o, tx_ready_o, spi_wr_o, spi_reg_sel_o, spi_data_o, spi_addr_o, rx_data_o).
REQ-027 Reset mid-transaction SHALL abort it with no done_o/err_o pulse; the SPI itself is reset by the same reset_pi.

Verification
REQ-028 N=3, bytes A5,3C,FF, SPI model clears send after 40 cycles -> data writes addr 0..2, control write 0x0000_0021, rx bytes 0..2 echoed, done_o one pulse, busy_o low next cycle.
REQ-029 start_i with n_bytes_i=0 and with n_bytes_i=17 -> err_o one pulse, no spi_wr_o, back to IDLE.
REQ-030 SPI model never clears send, TIMEOUT=100 -> err_o pulse exactly 100 POLL cycles after entering POLL, no rx_valid_o.
REQ-031 N=4 with tx_valid_i low 5 cycles between bytes 1 and 2 -> no extra writes, addresses contiguous 0..3, control n_tx_end=3.
REQ-032 reset_pi asserted during POLL -> all outputs 0 same cycle, no done_o/err_o; fresh start_i afterwards completes normally.
REQ-033 start_i pulsed while busy_o=1 -> ignored, current transaction unaffected.
